// File: rtl/cluster_periph_demux_if.sv
// Core-style request/response bundle between the cluster
// peripheral crossbar and the peripheral demux.
interface cluster_periph_demux_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic                 req;
  logic [AddrWidth-1:0] add;
  logic                 we;
  logic [DataWidth-1:0] wdata;
  logic [BeWidth-1:0]   be;
  logic                 gnt;
  logic                 r_valid;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_opc;

  modport master (
    output req, add, we, wdata, be,
    input  gnt, r_valid, r_rdata, r_opc
  );

  modport slave (
    input  req, add, we, wdata, be,
    output gnt, r_valid, r_rdata, r_opc
  );
endinterface

// File: rtl/cluster_periph_demux.sv
// Address-window demux from one core-style request stream to
// NumSlv peripheral ports, with in-order responses and error slot.
module cluster_periph_demux #(
  parameter int unsigned NumSlv         = 12,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned RegionLog2     = 10,
  parameter int unsigned SlotWidth      = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [DataWidth-1:0] ErrRdata =
    DataWidth'(32'hBADACCE5)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  cluster_periph_demux_if.slave       slv,
  output logic [NumSlv-1:0]           mst_req_o,
  output logic [AddrWidth-1:0]        mst_add_o,
  output logic                        mst_we_o,
  output logic [DataWidth-1:0]        mst_wdata_o,
  output logic [DataWidth/8-1:0]      mst_be_o,
  input  logic [NumSlv-1:0]           mst_gnt_i,
  input  logic [NumSlv-1:0]           mst_r_valid_i,
  input  logic [NumSlv*DataWidth-1:0] mst_r_rdata_i,
  input  logic [NumSlv-1:0]           mst_r_opc_i,
  output logic                        unexpected_rsp_o
);
  localparam int unsigned TgtW = $clog2(NumSlv + 1);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [TgtW-1:0] ErrTgt = TgtW'(NumSlv);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [SlotWidth-1:0] slot;
  logic                 tgt_err;
  logic [TgtW-1:0]      tgt;
  logic                 allowed;
  logic                 port_gnt;
  logic                 gnt;

  logic                 rsp_valid;
  logic [DataWidth-1:0] rsp_rdata;
  logic                 rsp_opc;
  logic                 unexp;

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [TgtW-1:0]      last_q, last_d;
  logic                 err_pend_q, err_pend_d;

  // Request fields fan out unchanged to every port.
  assign mst_add_o   = slv.add;
  assign mst_we_o    = slv.we;
  assign mst_wdata_o = slv.wdata;
  assign mst_be_o    = slv.be;

  // Decode the target and forward only when ordering allows it.
  always_comb begin
    slot     = slv.add[RegionLog2 +: SlotWidth];
    tgt_err  = 32'(slot) >= NumSlv;
    tgt      = tgt_err ? ErrTgt : TgtW'(slot);
    allowed  = (cnt_q != CntMax) &&
               ((cnt_q == '0) || (tgt == last_q));
    mst_req_o = '0;
    port_gnt  = 1'b0;
    for (int unsigned i = 0; i < NumSlv; i++) begin
      if (!tgt_err && (tgt == TgtW'(i))) begin
        mst_req_o[i] = slv.req & allowed;
        port_gnt     = mst_gnt_i[i];
      end
    end
    gnt = slv.req & allowed & (tgt_err | port_gnt);
  end

  // Select the response of the owning target; flag strays.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_opc   = 1'b0;
    unexp     = 1'b0;
    if ((cnt_q != '0) && (last_q == ErrTgt) && err_pend_q) begin
      rsp_valid = 1'b1;
      rsp_rdata = ErrRdata;
      rsp_opc   = 1'b1;
    end
    for (int unsigned i = 0; i < NumSlv; i++) begin
      if (mst_r_valid_i[i]) begin
        if ((cnt_q != '0) && (last_q == TgtW'(i))) begin
          rsp_valid = 1'b1;
          rsp_rdata = mst_r_rdata_i[i*DataWidth +: DataWidth];
          rsp_opc   = mst_r_opc_i[i];
        end else begin
          unexp = 1'b1;
        end
      end
    end
  end

  assign slv.gnt          = gnt;
  assign slv.r_valid      = rsp_valid;
  assign slv.r_rdata      = rsp_rdata;
  assign slv.r_opc        = rsp_opc;
  assign unexpected_rsp_o = unexp;

  // Outstanding count, owning target and error-slot response.
  always_comb begin
    cnt_d      = cnt_q;
    last_d     = gnt ? tgt : last_q;
    err_pend_d = gnt & tgt_err;
    unique case ({gnt, rsp_valid})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      last_q     <= '0;
      err_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      err_pend_q <= err_pend_d;
    end
  end
endmodule

// File: tb/tb_cluster_periph_demux.sv
// Bench for cluster_periph_demux: directed cases, then random
// traffic against a queue-based reference with a response scoreboard.
module tb_cluster_periph_demux;
  localparam int NS = 12;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int ET = 12;
  localparam logic [31:0] ERR_D = 32'hBADACCE5;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cluster_periph_demux_if #(.AddrWidth(AW), .DataWidth(DW)) slv ();

  logic [NS-1:0]    mst_req;
  logic [AW-1:0]    mst_add;
  logic             mst_we;
  logic [DW-1:0]    mst_wdata;
  logic [DW/8-1:0]  mst_be;
  logic [NS-1:0]    mst_gnt;
  logic [NS-1:0]    mst_rv;
  logic [NS*DW-1:0] mst_rdata;
  logic [NS-1:0]    mst_ropc;
  logic             unexp;

  cluster_periph_demux dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .slv              (slv),
    .mst_req_o        (mst_req),
    .mst_add_o        (mst_add),
    .mst_we_o         (mst_we),
    .mst_wdata_o      (mst_wdata),
    .mst_be_o         (mst_be),
    .mst_gnt_i        (mst_gnt),
    .mst_r_valid_i    (mst_rv),
    .mst_r_rdata_i    (mst_rdata),
    .mst_r_opc_i      (mst_ropc),
    .unexpected_rsp_o (unexp)
  );

  int errors = 0;
  int checks = 0;
  rsp_t sb[$];

  int          q_out[$];
  int          due_q[NS+1][$];
  logic [31:0] dq[NS][$];
  logic        oq[NS][$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    slv.req = 1'b0;
    mst_gnt = '0;
    mst_rv  = '0;
  endtask

  task automatic sreq(input logic [31:0] a, input logic w);
    slv.req   = 1'b1;
    slv.add   = a;
    slv.we    = w;
    slv.wdata = $urandom;
    slv.be    = 4'hF;
  endtask

  task automatic set_rsp(input int p, input logic [31:0] d,
                         input logic o);
    mst_rv[p]            = 1'b1;
    mst_rdata[p*DW +: DW] = d;
    mst_ropc[p]          = o;
  endtask

  // Monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin : mon
    rsp_t e;
    if (slv.r_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_extra: got r_valid=1 want none");
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", slv.r_rdata, e.d);
        chk("rsp_opc", 32'(slv.r_opc), 32'(e.o));
      end
    end
  end

  logic [31:0]   a;
  logic [NS-1:0] er;
  logic [31:0]   rd;
  logic          ro;
  bit            active;
  bit            erf;
  bit            exp_rv;
  bit            ok;
  bit            eg;
  int            slot;
  int            mt;
  int            fav;
  int            rp;
  int            ri;

  initial begin
    idle();
    slv.add   = '0;
    slv.we    = 1'b0;
    slv.wdata = '0;
    slv.be    = '0;
    mst_rdata = '0;
    mst_ropc  = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'(slv.gnt), 0);
    chk("rst_rvalid", 32'(slv.r_valid), 0);
    chk("rst_rdata", slv.r_rdata, 0);
    chk("rst_req", 32'(mst_req), 0);
    chk("rst_unexp", 32'(unexp), 0);
    step();
    rst_n = 1'b1;

    // Read to slot 1 answered one cycle later.
    step();
    sreq(32'h400, 1'b0);
    mst_gnt[1] = 1'b1;
    sb.push_back('{32'h1234, 1'b0});
    @(negedge clk);
    chk("t1_req", 32'(mst_req), 32'h002);
    chk("t1_gnt", 32'(slv.gnt), 1);
    step();
    idle();
    set_rsp(1, 32'h1234, 1'b0);
    @(negedge clk);
    chk("t1_rvalid", 32'(slv.r_valid), 1);

    // Unmapped slot 12 handled by the error responder.
    step();
    idle();
    sreq(32'h3000, 1'b0);
    sb.push_back('{ERR_D, 1'b1});
    @(negedge clk);
    chk("t2_gnt", 32'(slv.gnt), 1);
    chk("t2_req", 32'(mst_req), 0);
    chk("t2_rv_early", 32'(slv.r_valid), 0);
    step();
    idle();
    @(negedge clk);
    chk("t2_rvalid", 32'(slv.r_valid), 1);
    step();
    @(negedge clk);
    chk("t2_rv_once", 32'(slv.r_valid), 0);

    // Four writes fill the window; the fifth waits for a response.
    step();
    sreq(32'h1800, 1'b1);
    mst_gnt[6] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{32'h600 + i, 1'b0});
      @(negedge clk);
      chk("t3_gnt", 32'(slv.gnt), 1);
      step();
    end
    @(negedge clk);
    chk("t3_full_gnt", 32'(slv.gnt), 0);
    chk("t3_full_req", 32'(mst_req), 0);
    step();
    set_rsp(6, 32'h600, 1'b0);
    @(negedge clk);
    chk("t3_rv", 32'(slv.r_valid), 1);
    chk("t3_gnt_held", 32'(slv.gnt), 0);
    step();
    mst_rv = '0;
    sb.push_back('{32'h604, 1'b0});
    @(negedge clk);
    chk("t3_regnt", 32'(slv.gnt), 1);
    step();
    idle();
    for (int i = 1; i < 5; i++) begin
      set_rsp(6, 32'h600 + i, 1'b0);
      @(negedge clk);
      chk("t3_drain", 32'(slv.r_valid), 1);
      step();
    end
    idle();

    // Target switch stalls until the previous target drains.
    sreq(32'h400, 1'b0);
    mst_gnt = '1;
    sb.push_back('{32'h4111, 1'b0});
    @(negedge clk);
    chk("t4_gnt1", 32'(slv.gnt), 1);
    step();
    sreq(32'h800, 1'b0);
    @(negedge clk);
    chk("t4_stall_req", 32'(mst_req), 0);
    chk("t4_stall_gnt", 32'(slv.gnt), 0);
    step();
    set_rsp(1, 32'h4111, 1'b0);
    @(negedge clk);
    chk("t4_rv1", 32'(slv.r_valid), 1);
    chk("t4_still_stall", 32'(slv.gnt), 0);
    step();
    mst_rv = '0;
    sb.push_back('{32'h4222, 1'b1});
    @(negedge clk);
    chk("t4_fwd_req", 32'(mst_req), 32'h004);
    chk("t4_fwd_gnt", 32'(slv.gnt), 1);
    step();
    idle();
    set_rsp(2, 32'h4222, 1'b1);
    @(negedge clk);
    chk("t4_rv2", 32'(slv.r_valid), 1);
    step();
    idle();

    // Stray response with nothing outstanding.
    set_rsp(5, 32'h5555, 1'b0);
    @(negedge clk);
    chk("t5_rv", 32'(slv.r_valid), 0);
    chk("t5_unexp", 32'(unexp), 1);
    step();
    idle();
    @(negedge clk);
    chk("t5_unexp_pulse", 32'(unexp), 0);

    // Reset with three in flight; late response is dropped.
    step();
    sreq(32'hC00, 1'b0);
    mst_gnt[3] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_gnt", 32'(slv.gnt), 1);
      step();
    end
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_unexp", 32'(unexp), 0);
    step();
    rst_n = 1'b1;
    set_rsp(3, 32'h3333, 1'b0);
    @(negedge clk);
    chk("t6_drop_rv", 32'(slv.r_valid), 0);
    chk("t6_flag", 32'(unexp), 1);
    step();
    idle();
    sreq(32'h1C00, 1'b0);
    mst_gnt[7] = 1'b1;
    sb.push_back('{32'h7777, 1'b0});
    @(negedge clk);
    chk("t6_post_gnt", 32'(slv.gnt), 1);
    step();
    idle();
    set_rsp(7, 32'h7777, 1'b0);
    @(negedge clk);
    chk("t6_post_rv", 32'(slv.r_valid), 1);
    step();
    idle();

    // Random traffic against the reference model.
    active = 1'b0;
    fav    = 1;
    mt     = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      mst_rv = '0;
      for (int p = 0; p < NS; p++) begin
        if (due_q[p].size() > 0 && due_q[p][0] <= c)
          set_rsp(p, dq[p][0], oq[p][0]);
      end
      mst_gnt = NS'($urandom) | NS'($urandom);
      if (!active && c < 2800 && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 7) == 0) fav = $urandom_range(0, 15);
        slot = ($urandom_range(0, 4) == 0) ?
               $urandom_range(0, 15) : fav;
        a        = $urandom;
        a[13:10] = 4'(slot);
        sreq(a, 1'($urandom));
        mt     = (slot < NS) ? slot : ET;
        active = 1'b1;
      end else if (!active) begin
        slv.req = 1'b0;
      end
      @(negedge clk);
      rp = -1;
      for (int p = 0; p < NS; p++) if (mst_rv[p]) rp = p;
      erf = due_q[ET].size() > 0 && due_q[ET][0] <= c;
      exp_rv = (rp >= 0) || erf;
      chk("rnd_rvalid", 32'(slv.r_valid), 32'(exp_rv));
      chk("rnd_unexp", 32'(unexp), 0);
      ok = active && (q_out.size() == 0 ||
           (q_out.size() < 4 && q_out[0] == mt));
      eg = ok && (mt == ET || mst_gnt[mt]);
      er = '0;
      if (ok && mt < NS) er[mt] = 1'b1;
      chk("rnd_gnt", 32'(slv.gnt), 32'(eg));
      chk("rnd_req", 32'(mst_req), 32'(er));
      if (exp_rv) begin
        ri = (rp >= 0) ? rp : ET;
        void'(due_q[ri].pop_front());
        if (rp >= 0) begin
          void'(dq[rp].pop_front());
          void'(oq[rp].pop_front());
        end
        void'(q_out.pop_front());
      end
      if (eg) begin
        q_out.push_back(mt);
        active = 1'b0;
        if (mt == ET) begin
          due_q[ET].push_back(c + 1);
          sb.push_back('{ERR_D, 1'b1});
        end else begin
          rd = $urandom;
          ro = 1'($urandom_range(0, 1));
          due_q[mt].push_back(c + $urandom_range(1, 3));
          dq[mt].push_back(rd);
          oq[mt].push_back(ro);
          sb.push_back('{rd, ro});
        end
      end
    end
    idle();
    @(negedge clk);
    chk("end_sb_empty", 32'(sb.size()), 0);
    chk("end_out_empty", 32'(q_out.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
